// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit.
// Holds the destination tag and raises multdiv_on while busy.
module multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [TAG_W-1:0] rd_in,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic [TAG_W-1:0] rd_out,
  output logic             multdiv_on
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             exc_q, exc_d;
  logic [TAG_W-1:0] rdo_q, rdo_d;

  logic             idle, start_m, start_d, b_zero, last;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   m_ext, booth_sum;
  logic [2*WIDTH+1:0] booth_sh;
  logic [WIDTH:0]   rem_sh, diff;
  logic             ge;
  logic [WIDTH-1:0] quo_n;

  assign idle    = (state_q == IDLE);
  assign start_m = idle && ctrl_MULT;
  assign start_d = idle && ctrl_DIV && !ctrl_MULT;
  assign b_zero  = (data_operandB == '0);
  assign last    = (cnt_q == CW'(WIDTH - 1));
  assign a_mag   = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign b_mag   = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  // Accumulator is one bit wider so -M never overflows for M = min int
  assign m_ext = {m_q[WIDTH-1], m_q};

  always_comb begin
    booth_sum = acc_q;
    unique case ({q_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_ext;
      2'b10:   booth_sum = acc_q - m_ext;
      default: booth_sum = acc_q;
    endcase
  end

  assign booth_sh = {booth_sum[WIDTH], booth_sum, q_q};

  assign rem_sh = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, m_q};
  assign ge     = !diff[WIDTH];
  assign quo_n  = {q_q[WIDTH-2:0], ge};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      tag_q   <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      rdo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      rdo_q   <= rdo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_m)               state_d = MULT;
        else if (start_d && b_zero) state_d = DONE;
        else if (start_d)          state_d = DIV;
      end
      MULT:    if (last) state_d = DONE;
      DIV:     if (last) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    q_d   = q_q;
    qm1_d = qm1_q;
    m_d   = m_q;
    neg_d = neg_q;
    ovf_d = ovf_q;
    tag_d = tag_q;
    res_d = res_q;
    exc_d = exc_q;
    rdo_d = rdo_q;
    unique case (state_q)
      IDLE: begin
        if (start_m) begin
          cnt_d = '0;
          acc_d = '0;
          q_d   = data_operandB;
          qm1_d = 1'b0;
          m_d   = data_operandA;
          tag_d = rd_in;
        end else if (start_d && b_zero) begin
          res_d = '0;
          exc_d = 1'b1;
          rdo_d = rd_in;
        end else if (start_d) begin
          cnt_d = '0;
          acc_d = '0;
          q_d   = a_mag;
          qm1_d = 1'b0;
          m_d   = b_mag;
          neg_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          ovf_d = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                  (data_operandB == '1);
          tag_d = rd_in;
        end
      end
      MULT: begin
        cnt_d = cnt_q + 1'b1;
        acc_d = booth_sh[2*WIDTH+1:WIDTH+1];
        q_d   = booth_sh[WIDTH:1];
        qm1_d = booth_sh[0];
        if (last) begin
          res_d = booth_sh[WIDTH:1];
          exc_d = booth_sh[2*WIDTH:WIDTH+1] != {WIDTH{booth_sh[WIDTH]}};
          rdo_d = tag_q;
        end
      end
      DIV: begin
        cnt_d = cnt_q + 1'b1;
        acc_d = ge ? diff : rem_sh;
        q_d   = quo_n;
        if (last) begin
          res_d = neg_q ? -quo_n : quo_n;
          exc_d = ovf_q;
          rdo_d = tag_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    data_result    = res_q;
    data_exception = exc_q;
    rd_out         = rdo_q;
    data_resultRDY = (state_q == DONE);
    multdiv_on     = (state_q != IDLE);
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: latency, results, exceptions,
// ignored starts, divide-by-zero and reset abort.
module tb_multdiv_unit;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [4:0]  rd_in;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic [4:0]  rd_out;
  logic        multdiv_on;

  int n_run  = 0;
  int n_fail = 0;

  multdiv_unit dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .rd_in          (rd_in),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .rd_out         (rd_out),
    .multdiv_on     (multdiv_on)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts an op at the next edge, then checks the 32-cycle latency,
  // the DONE pulse and the return to idle.
  task automatic run_op(input string tag, input bit do_mult,
                        input bit both, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] er, input logic ee,
                        input int inject, input bit pulse_done);
    int early;
    early = 0;
    data_operandA = a;
    data_operandB = b;
    rd_in = rd;
    ctrl_MULT = do_mult | both;
    ctrl_DIV = !do_mult | both;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = a ^ 32'h5a5a_1234;
    data_operandB = 32'h0;
    rd_in = ~rd;
    chk({tag, "_busy"}, {63'd0, multdiv_on}, 64'd1);
    for (int i = 1; i < 32; i++) begin
      @(posedge clock); #1;
      ctrl_DIV = 1'b0;
      if (data_resultRDY) early++;
      if (i == inject) begin
        ctrl_DIV = 1'b1;
        data_operandB = 32'h0;
      end
    end
    chk({tag, "_early_rdy"}, 64'(early), 64'd0);
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    chk({tag, "_rdy"}, {63'd0, data_resultRDY}, 64'd1);
    chk({tag, "_res"}, {32'd0, data_result}, {32'd0, er});
    chk({tag, "_exc"}, {63'd0, data_exception}, {63'd0, ee});
    chk({tag, "_rd"}, {59'd0, rd_out}, {59'd0, rd});
    if (pulse_done) ctrl_MULT = 1'b1;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    chk({tag, "_idle"}, {62'd0, multdiv_on, data_resultRDY}, 64'd0);
    chk({tag, "_hold"}, {32'd0, data_result}, {32'd0, er});
  endtask

  initial begin
    reset = 1'b1;
    data_operandA = '0;
    data_operandB = '0;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    rd_in = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_out",
        {24'd0, data_result, data_exception, data_resultRDY, rd_out,
         multdiv_on}, 64'd0);
    reset = 1'b0;

    run_op("mul_7x-3", 1, 0, 32'd7, 32'hffff_fffd, 5'd5,
           32'hffff_ffeb, 0, 0, 0);
    run_op("mul_ovf", 1, 0, 32'h0001_0000, 32'h0001_0000, 5'd3,
           32'h0, 1, 0, 0);
    run_op("mul_min", 1, 0, 32'h8000_0000, 32'd1, 5'd9,
           32'h8000_0000, 0, 0, 0);
    run_op("div_-100/7", 0, 0, 32'hffff_ff9c, 32'd7, 5'd12,
           32'hffff_fff2, 0, 0, 0);
    run_op("div_min/-1", 0, 0, 32'h8000_0000, 32'hffff_ffff, 5'd1,
           32'h8000_0000, 1, 0, 0);
    run_op("div_-21/-3", 0, 0, 32'hffff_ffeb, 32'hffff_fffd, 5'd7,
           32'd7, 0, 0, 0);
    run_op("div_7/100", 0, 0, 32'd7, 32'd100, 5'd8,
           32'd0, 0, 0, 0);

    // divide by zero: straight to DONE
    data_operandA = 32'd42;
    data_operandB = 32'd0;
    rd_in = 5'd4;
    ctrl_DIV = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    chk("dz_rdy", {62'd0, data_resultRDY, multdiv_on}, 64'd3);
    chk("dz_res", {27'd0, data_result, data_exception, rd_out},
        {27'd0, 32'd0, 1'b1, 5'd4});
    @(posedge clock); #1;
    chk("dz_idle", {62'd0, data_resultRDY, multdiv_on}, 64'd0);

    run_op("mul_3x4_inj", 1, 0, 32'd3, 32'd4, 5'd2,
           32'd12, 0, 10, 1);
    chk("done_pulse_ignored", {63'd0, multdiv_on}, 64'd0);
    run_op("mul_div_both", 1, 1, 32'd6, 32'd2, 5'd6,
           32'd12, 0, 0, 0);

    // reset aborts a divide after 15 cycles
    data_operandA = 32'd1000;
    data_operandB = 32'd3;
    rd_in = 5'd20;
    ctrl_DIV = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    repeat (14) @(posedge clock);
    #1;
    chk("pre_reset_busy", {63'd0, multdiv_on}, 64'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("abort_out",
        {24'd0, data_result, data_exception, data_resultRDY, rd_out,
         multdiv_on}, 64'd0);
    run_op("mul_2x5_post", 1, 0, 32'd2, 32'd5, 5'd11,
           32'd10, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
